jts16_obj_scan: RTL

Per-scanline object table scanner for the System 16 sprite path. It walks the object table RAM once per line and tests each entry's vertical range against the line being prepared. For every visible entry it computes and writes back the running graphics address, then hands a draw request to the line-buffer drawer through a valid/ready handshake. It sits between the object table RAM's video port and the object draw unit.

---
 rtl/jts16_obj_scan.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/jts16_obj_scan.sv
// Per-scanline object table scanner: range-checks entries and issues draw requests.
// Optional JTS16_OBJ_WRBACK_EN: accumulate the graphics address and write it back to word7.
module jts16_obj_scan #(
  parameter int unsigned OBJW = 7
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            hstart,
  input  logic [8:0]      vrender,
  input  logic            tbl_page,
  output logic [OBJW+3:0] tbl_addr,
  input  logic [15:0]     tbl_dout,
  output logic            tbl_we,
  output logic [15:0]     tbl_din,
  output logic            dr_valid,
  input  logic            dr_ready,
  output logic [8:0]      dr_xpos,
  output logic [15:0]     dr_pitch,
  output logic [15:0]     dr_addr,
  output logic [3:0]      dr_bank,
  output logic [1:0]      dr_prio,
  output logic            dr_hflip,
  output logic            busy
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RD0   = 3'd1;
  localparam logic [2:0] ST_CHK   = 3'd2;
  localparam logic [2:0] ST_FETCH = 3'd3;
  localparam logic [2:0] ST_EMIT  = 3'd5;
`ifdef JTS16_OBJ_WRBACK_EN
  localparam logic [2:0] ST_WB      = 3'd4;
  localparam logic [2:0] FETCH_LAST = 3'd5;
`else
  localparam logic [2:0] FETCH_LAST = 3'd4;
`endif

  logic [2:0]      r_state, w_state_nx;
  logic [OBJW-1:0] r_idx, w_idx_nx;
  logic [OBJW+3:0] r_addr, w_addr_nx;
  logic            r_page, w_page_nx;
  logic [7:0]      r_line, w_line_nx;
  logic [7:0]      r_top, w_top_nx;
  logic [2:0]      r_cnt, w_cnt_nx;
  logic [15:0]     r_word3, w_word3_nx;
  logic [8:0]      r_xpos, w_xpos_nx;
  logic [15:0]     r_pitch, w_pitch_nx;
  logic [15:0]     r_daddr, w_daddr_nx;
  logic [3:0]      r_bank, w_bank_nx;
  logic [1:0]      r_prio, w_prio_nx;
  logic            r_hflip, w_hflip_nx;
  logic            r_valid, w_valid_nx;
`ifdef JTS16_OBJ_WRBACK_EN
  logic            r_we, w_we_nx;
  logic [15:0]     r_din, w_din_nx;
  logic [15:0]     w_cur;
`endif

  logic [7:0]      w_top, w_bot;
  logic            w_last;
  logic            w_unused;

  assign w_top  = tbl_dout[7:0];
  assign w_bot  = tbl_dout[15:8];
  assign w_last = (r_idx == {OBJW{1'b1}});

`ifdef JTS16_OBJ_WRBACK_EN
  // First visible line restarts from the base address, later lines advance by the pitch
  assign w_cur    = (r_line == r_top) ? r_word3 : 16'(tbl_dout + r_pitch);
  assign w_unused = vrender[8];
`else
  assign w_unused = ^{vrender[8], r_top};
`endif

  // Word offset issued on each FETCH step: 1, 2, 3, 4 then 7
  function automatic logic [2:0] fetch_word(input logic [2:0] k);
    case (k)
      3'd0:    fetch_word = 3'd1;
      3'd1:    fetch_word = 3'd2;
      3'd2:    fetch_word = 3'd3;
      3'd3:    fetch_word = 3'd4;
      default: fetch_word = 3'd7;
    endcase
  endfunction

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_addr_nx  = r_addr;
    w_page_nx  = r_page;
    w_line_nx  = r_line;
    w_top_nx   = r_top;
    w_cnt_nx   = r_cnt;
    w_word3_nx = r_word3;
    w_xpos_nx  = r_xpos;
    w_pitch_nx = r_pitch;
    w_daddr_nx = r_daddr;
    w_bank_nx  = r_bank;
    w_prio_nx  = r_prio;
    w_hflip_nx = r_hflip;
    w_valid_nx = r_valid;
`ifdef JTS16_OBJ_WRBACK_EN
    w_we_nx    = r_we;
    w_din_nx   = r_din;
`endif
    case (r_state)
      ST_RD0: w_state_nx = ST_CHK;
      ST_CHK: begin
        if (w_bot == 8'hFF) begin
          w_state_nx = ST_IDLE;
        end else if (r_line >= w_top && r_line < w_bot) begin
          w_top_nx   = w_top;
          w_cnt_nx   = 3'd0;
          w_addr_nx  = {r_page, r_idx, 3'd1};
          w_state_nx = ST_FETCH;
        end else if (w_last) begin
          w_state_nx = ST_IDLE;
        end else begin
          w_idx_nx   = r_idx + OBJW'(1);
          w_addr_nx  = {r_page, r_idx + OBJW'(1), 3'd0};
          w_state_nx = ST_RD0;
        end
      end
      ST_FETCH: begin
        // Each word is captured one cycle after its address was issued
        w_cnt_nx = r_cnt + 3'd1;
        if (r_cnt < FETCH_LAST - 3'd1)
          w_addr_nx = {r_page, r_idx, fetch_word(r_cnt + 3'd1)};
        case (r_cnt)
          3'd1: w_xpos_nx  = tbl_dout[8:0];
          3'd2: w_pitch_nx = tbl_dout;
          3'd3: w_word3_nx = tbl_dout;
          3'd4: begin
            w_bank_nx  = tbl_dout[11:8];
            w_prio_nx  = tbl_dout[1:0];
            w_hflip_nx = tbl_dout[8];
          end
          default: ;
        endcase
        if (r_cnt == FETCH_LAST) begin
`ifdef JTS16_OBJ_WRBACK_EN
          w_we_nx    = 1'b1;
          w_din_nx   = w_cur;
          w_daddr_nx = w_cur;
          w_state_nx = ST_WB;
`else
          w_daddr_nx = r_word3;
          w_valid_nx = 1'b1;
          w_state_nx = ST_EMIT;
`endif
        end
      end
`ifdef JTS16_OBJ_WRBACK_EN
      ST_WB: begin
        w_we_nx    = 1'b0;
        w_valid_nx = 1'b1;
        w_state_nx = ST_EMIT;
      end
`endif
      ST_EMIT: begin
        if (dr_ready) begin
          w_valid_nx = 1'b0;
          if (w_last) begin
            w_state_nx = ST_IDLE;
          end else begin
            w_idx_nx   = r_idx + OBJW'(1);
            w_addr_nx  = {r_page, r_idx + OBJW'(1), 3'd0};
            w_state_nx = ST_RD0;
          end
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
    // A new line start overrides everything, dropping any pending request or write
    if (hstart) begin
      w_state_nx = ST_RD0;
      w_idx_nx   = '0;
      w_page_nx  = tbl_page;
      w_line_nx  = vrender[7:0];
      w_addr_nx  = {tbl_page, {OBJW{1'b0}}, 3'd0};
      w_valid_nx = 1'b0;
`ifdef JTS16_OBJ_WRBACK_EN
      w_we_nx    = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_addr  <= '0;
      r_page  <= 1'b0;
      r_line  <= '0;
      r_top   <= '0;
      r_cnt   <= '0;
      r_word3 <= '0;
      r_xpos  <= '0;
      r_pitch <= '0;
      r_daddr <= '0;
      r_bank  <= '0;
      r_prio  <= '0;
      r_hflip <= 1'b0;
      r_valid <= 1'b0;
`ifdef JTS16_OBJ_WRBACK_EN
      r_we    <= 1'b0;
      r_din   <= '0;
`endif
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_addr  <= w_addr_nx;
      r_page  <= w_page_nx;
      r_line  <= w_line_nx;
      r_top   <= w_top_nx;
      r_cnt   <= w_cnt_nx;
      r_word3 <= w_word3_nx;
      r_xpos  <= w_xpos_nx;
      r_pitch <= w_pitch_nx;
      r_daddr <= w_daddr_nx;
      r_bank  <= w_bank_nx;
      r_prio  <= w_prio_nx;
      r_hflip <= w_hflip_nx;
      r_valid <= w_valid_nx;
`ifdef JTS16_OBJ_WRBACK_EN
      r_we    <= w_we_nx;
      r_din   <= w_din_nx;
`endif
    end
  end

  assign tbl_addr = r_addr;
  assign dr_valid = r_valid & ~hstart;
  assign dr_xpos  = r_xpos;
  assign dr_pitch = r_pitch;
  assign dr_addr  = r_daddr;
  assign dr_bank  = r_bank;
  assign dr_prio  = r_prio;
  assign dr_hflip = r_hflip;
  assign busy     = (r_state != ST_IDLE);
`ifdef JTS16_OBJ_WRBACK_EN
  assign tbl_we   = r_we & ~hstart;
  assign tbl_din  = r_din;
`else
  assign tbl_we   = 1'b0;
  assign tbl_din  = 16'h0000;
`endif

endmodule
